encoder_8b10b: RTL and testbench

Single-lane 8b/10b encoder directly downstream of the scrambler in the Gen1/Gen2 TX path. It takes scrambled data bytes or unscrambled control (K) characters and produces 10-bit symbols with running-disparity tracking. Flow control is valid/ready on both sides. Its output feeds the serializer.

---
 rtl/pcie_phy_pkg.sv | 23 ++
 rtl/enc_8b10b_lut.sv | 92 +++++++++
 rtl/encoder_8b10b.sv | 67 ++++++
 tb/tb_encoder_8b10b.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants: named K-character bytes, symbol width and the
// control-character legality check used by the 8b/10b encoder.
package pcie_phy_pkg;

    localparam int SYMBOL_WIDTH = 10;

    localparam logic [7:0] K28_5_COM = 8'hBC;
    localparam logic [7:0] K28_0_SKP = 8'h1C;
    localparam logic [7:0] K28_3_IDL = 8'h7C;
    localparam logic [7:0] K23_7_PAD = 8'hF7;
    localparam logic [7:0] K27_7_STP = 8'hFB;
    localparam logic [7:0] K29_7_END = 8'hFD;
    localparam logic [7:0] K30_7_EDB = 8'hFE;
    localparam logic [7:0] K28_2_SDP = 8'h5C;
    localparam logic [7:0] K28_1_FTS = 8'h3C;

    // Every K28.y is legal; the only other legal controls are the four Kx.7 codes.
    function automatic logic is_legal_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == K23_7_PAD) || (b == K27_7_STP) ||
               (b == K29_7_END) || (b == K30_7_EDB);
    endfunction

endpackage

// File: rtl/enc_8b10b_lut.sv
// Combinational 8b/10b code lookup: 5b/6b then 3b/4b, each sub-block chosen
// by the running disparity in force when it starts.
module enc_8b10b_lut
    import pcie_phy_pkg::*;
(
    input  logic [7:0]              data,
    input  logic                    k,
    input  logic                    rd,
    output logic [SYMBOL_WIDTH-1:0] code,
    output logic                    rd_next
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6_base, s6;
    logic [3:0] s4_base, s4;
    logic       neutral6, neutral4, rd_mid, alt7;

    assign x = data[4:0];
    assign y = data[7:5];

    always_comb begin
        // RD- column, written abcdei (a in the MSB)
        s6_base = 6'b000000;
        case (x)
            5'd0:  s6_base = 6'b100111;
            5'd1:  s6_base = 6'b011101;
            5'd2:  s6_base = 6'b101101;
            5'd3:  s6_base = 6'b110001;
            5'd4:  s6_base = 6'b110101;
            5'd5:  s6_base = 6'b101001;
            5'd6:  s6_base = 6'b011001;
            5'd7:  s6_base = 6'b111000;
            5'd8:  s6_base = 6'b111001;
            5'd9:  s6_base = 6'b100101;
            5'd10: s6_base = 6'b010101;
            5'd11: s6_base = 6'b110100;
            5'd12: s6_base = 6'b001101;
            5'd13: s6_base = 6'b101100;
            5'd14: s6_base = 6'b011100;
            5'd15: s6_base = 6'b010111;
            5'd16: s6_base = 6'b011011;
            5'd17: s6_base = 6'b100011;
            5'd18: s6_base = 6'b010011;
            5'd19: s6_base = 6'b110010;
            5'd20: s6_base = 6'b001011;
            5'd21: s6_base = 6'b101010;
            5'd22: s6_base = 6'b011010;
            5'd23: s6_base = 6'b111010;
            5'd24: s6_base = 6'b110011;
            5'd25: s6_base = 6'b100110;
            5'd26: s6_base = 6'b010110;
            5'd27: s6_base = 6'b110110;
            5'd28: s6_base = 6'b001110;
            5'd29: s6_base = 6'b101110;
            5'd30: s6_base = 6'b011110;
            default: s6_base = 6'b101011;
        endcase
        if (k && x == 5'd28)
            s6_base = 6'b001111;
        neutral6 = ($countones(s6_base) == 3);
        // D.7 is balanced but still has two forms to avoid a run of three
        s6     = (rd && (!neutral6 || x == 5'd7)) ? ~s6_base : s6_base;
        rd_mid = neutral6 ? rd : ~rd;

        alt7 = k || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                    (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        // RD- column, written fghj (f in the MSB)
        case (y)
            3'd0:    s4_base = 4'b1011;
            3'd1:    s4_base = k ? 4'b0110 : 4'b1001;
            3'd2:    s4_base = k ? 4'b1010 : 4'b0101;
            3'd3:    s4_base = 4'b1100;
            3'd4:    s4_base = 4'b1101;
            3'd5:    s4_base = k ? 4'b0101 : 4'b1010;
            3'd6:    s4_base = k ? 4'b1001 : 4'b0110;
            default: s4_base = alt7 ? 4'b0111 : 4'b1110;
        endcase
        neutral4 = ($countones(s4_base) == 2);
        s4       = (rd_mid && (!neutral4 || y == 3'd3 || k)) ? ~s4_base : s4_base;
        rd_next  = neutral4 ? rd_mid : ~rd_mid;
    end

    // Tables are written in transmit order; the symbol puts 'a' in bit 0.
    for (genvar gi = 0; gi < 6; gi++) begin : g_rev6
        assign code[gi] = s6[5-gi];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_rev4
        assign code[6+gi] = s4[3-gi];
    end

endmodule

// File: rtl/encoder_8b10b.sv
// Single-lane 8b/10b encoder: one output register stage with valid/ready on
// both sides and running-disparity state that advances only on accept.
module encoder_8b10b
    import pcie_phy_pkg::*;
#(
    parameter bit INIT_RD_POS = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              data_i,
    input  logic                    data_k_i,
    input  logic                    data_valid_i,
    output logic                    encoder_ready_o,
    output logic [SYMBOL_WIDTH-1:0] symbol_o,
    output logic                    symbol_valid_o,
    input  logic                    symbol_ready_i,
    output logic                    code_err_o,
    output logic                    rd_o
);

    logic [SYMBOL_WIDTH-1:0] symbol_reg;
    logic                    symbol_valid_reg;
    logic                    code_err_reg;
    logic                    rd_reg;
    logic [SYMBOL_WIDTH-1:0] lut_code;
    logic                    lut_rd_next;
    logic                    k_illegal;
    logic [7:0]              lut_byte;
    logic                    accept;

    // An illegal control is replaced by a comma so the link keeps a valid stream.
    assign k_illegal = data_k_i && !is_legal_k(data_i);
    assign lut_byte  = k_illegal ? K28_5_COM : data_i;

    enc_8b10b_lut u_lut (
        .data    (lut_byte),
        .k       (data_k_i),
        .rd      (rd_reg),
        .code    (lut_code),
        .rd_next (lut_rd_next)
    );

    assign encoder_ready_o = !symbol_valid_reg || symbol_ready_i;
    assign accept          = data_valid_i && encoder_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            symbol_reg       <= '0;
            symbol_valid_reg <= 1'b0;
            code_err_reg     <= 1'b0;
            rd_reg           <= INIT_RD_POS;
        end else if (accept) begin
            symbol_reg       <= lut_code;
            symbol_valid_reg <= 1'b1;
            code_err_reg     <= k_illegal;
            rd_reg           <= lut_rd_next;
        end else if (symbol_ready_i) begin
            symbol_valid_reg <= 1'b0;
        end
    end

    assign symbol_o       = symbol_reg;
    assign symbol_valid_o = symbol_valid_reg;
    assign code_err_o     = code_err_reg;
    assign rd_o           = rd_reg;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Self-checking bench for encoder_8b10b: directed literal vectors, backpressure,
// and a randomized byte/K stream checked cycle by cycle against a table model.
module tb_encoder_8b10b;

    localparam bit INIT_RD = 1'b0;

    // Standard 5b/6b table, both columns, abcdei with 'a' in the MSB
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    // 3b/4b tables, fghj with 'f' in the MSB, indexed by RD at the start of the 4b block
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                           8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       data_k_i = 1'b0;
    logic       data_valid_i = 1'b0;
    logic       encoder_ready_o;
    logic [9:0] symbol_o;
    logic       symbol_valid_o;
    logic       symbol_ready_i = 1'b1;
    logic       code_err_o;
    logic       rd_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    // Model state: the register contents the DUT must hold after the latest edge
    logic       m_valid = 1'b0;
    logic [9:0] m_sym   = '0;
    logic       m_err   = 1'b0;
    logic       m_rd    = INIT_RD;
    logic       m_rdb   = INIT_RD;
    int         run_len  = 0;
    logic       run_bit  = 1'b0;

    encoder_8b10b #(.INIT_RD_POS(INIT_RD)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .data_i          (data_i),
        .data_k_i        (data_k_i),
        .data_valid_i    (data_valid_i),
        .encoder_ready_o (encoder_ready_o),
        .symbol_o        (symbol_o),
        .symbol_valid_o  (symbol_valid_o),
        .symbol_ready_i  (symbol_ready_i),
        .code_err_o      (code_err_o),
        .rd_o            (rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_enc(input logic [7:0] b, input logic k, input logic rd,
                                      output logic [9:0] sym, output logic rd_out, output logic err);
        logic [7:0] v;
        int x, y, d;
        logic r, alt;
        logic [5:0] s6;
        logic [3:0] s4;
        err = k && !(b inside {LEGAL_K});
        v = err ? 8'hBC : b;
        x = int'(v[4:0]);
        y = int'(v[7:5]);
        if (k && x == 28) s6 = rd ? 6'b110000 : 6'b001111;
        else              s6 = rd ? T6P[x] : T6N[x];
        r = rd;
        d = $countones(s6) - 3;
        if (d > 0) r = 1'b1; else if (d < 0) r = 1'b0;
        if (y == 7) begin
            alt = k || (!r && (x inside {17, 18, 20})) || (r && (x inside {11, 13, 14}));
            s4 = alt ? (r ? 4'b1000 : 4'b0111) : (r ? 4'b0001 : 4'b1110);
        end else if (k) begin
            s4 = r ? K4P[y] : K4N[y];
        end else begin
            s4 = r ? T4P[y] : T4N[y];
        end
        d = $countones(s4) - 2;
        if (d > 0) r = 1'b1; else if (d < 0) r = 1'b0;
        for (int i = 0; i < 6; i++) sym[i] = s6[5-i];
        for (int i = 0; i < 4; i++) sym[6+i] = s4[3-i];
        rd_out = r;
    endfunction

    // Compare process: checks outputs against the model, then advances the model
    // with the inputs that the coming rising edge will see.
    initial begin
        logic [9:0] nsym;
        logic nrd, nerr, ok;
        int worst, disp;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                chk("rst_symbol_valid", 32'(symbol_valid_o), 32'(0));
                chk("rst_symbol", 32'(symbol_o), 32'(0));
                chk("rst_code_err", 32'(code_err_o), 32'(0));
                chk("rst_rd", 32'(rd_o), 32'(INIT_RD));
                m_valid = 1'b0; m_sym = '0; m_err = 1'b0; m_rd = INIT_RD;
                run_len = 0;
            end else begin
                chk("symbol_valid", 32'(symbol_valid_o), 32'(m_valid));
                chk("rd", 32'(rd_o), 32'(m_rd));
                chk("ready", 32'(encoder_ready_o), 32'(!m_valid || symbol_ready_i));
                if (m_valid) begin
                    chk("symbol", 32'(symbol_o), 32'(m_sym));
                    chk("code_err", 32'(code_err_o), 32'(m_err));
                end
                if (m_valid && symbol_ready_i) begin
                    n_pops++;
                    disp = 2 * $countones(symbol_o) - 10;
                    ok = m_rdb ? (disp == 0 || disp == -2) : (disp == 0 || disp == 2);
                    chk("disparity", 32'(ok), 32'(1));
                    worst = 0;
                    for (int i = 0; i < 10; i++) begin
                        if (run_len > 0 && symbol_o[i] == run_bit) run_len++;
                        else begin run_len = 1; run_bit = symbol_o[i]; end
                        if (run_len > worst) worst = run_len;
                    end
                    chk("run_length_le5", 32'(worst > 5), 32'(0));
                    $display("sym %0d: %b err=%0d rd=%0d", n_pops, symbol_o, code_err_o, rd_o);
                end
                if (data_valid_i && (!m_valid || symbol_ready_i)) begin
                    model_enc(data_i, data_k_i, m_rd, nsym, nrd, nerr);
                    m_rdb = m_rd;
                    m_sym = nsym; m_rd = nrd; m_err = nerr; m_valid = 1'b1;
                end else if (symbol_ready_i) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // One directed byte with the sink always ready; pins both the DUT and the model.
    task automatic send_chk(input string name, input logic [7:0] b, input logic k,
                            input logic [9:0] exp_sym, input logic exp_rd, input logic exp_err);
        data_i = b; data_k_i = k; data_valid_i = 1'b1; symbol_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_valid_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_valid"}, 32'(symbol_valid_o), 32'(1));
        chk({name, "_sym"}, 32'(symbol_o), 32'(exp_sym));
        chk({name, "_rd"}, 32'(rd_o), 32'(exp_rd));
        chk({name, "_err"}, 32'(code_err_o), 32'(exp_err));
        chk({name, "_model"}, 32'(m_sym), 32'(exp_sym));
        $display("directed %s: byte=%h k=%0d -> %h rd=%0d err=%0d", name, b, k, symbol_o, rd_o, code_err_o);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_bytes [3];
        logic acc, did_rst;
        int n, cyc, r;

        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(encoder_ready_o), 32'(1));
        chk("idle_valid", 32'(symbol_valid_o), 32'(0));
        @(posedge clk_i); #1;

        send_chk("k28_5_rdn", 8'hBC, 1'b1, 10'h17C, 1'b1, 1'b0);
        send_chk("k28_5_rdp", 8'hBC, 1'b1, 10'h283, 1'b0, 1'b0);
        // D0.0 is balanced as a whole, so RD- is kept and the same code repeats
        send_chk("d0_0_a", 8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0);
        send_chk("d0_0_b", 8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0);
        send_chk("d21_5", 8'hB5, 1'b0, 10'h155, 1'b0, 1'b0);
        send_chk("k28_5_to_rdp", 8'hBC, 1'b1, 10'h17C, 1'b1, 1'b0);
        send_chk("d0_0_rdp", 8'h00, 1'b0, 10'h346, 1'b1, 1'b0);
        send_chk("k28_5_back", 8'hBC, 1'b1, 10'h283, 1'b0, 1'b0);
        send_chk("d17_7_alt", 8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0);
        send_chk("d11_7_alt", 8'hEB, 1'b0, 10'h04B, 1'b0, 1'b0);
        send_chk("illegal_k", 8'h00, 1'b1, 10'h17C, 1'b1, 1'b1);
        send_chk("legal_after", 8'hBC, 1'b1, 10'h283, 1'b0, 1'b0);
        send_chk("k23_7", 8'hF7, 1'b1, 10'h057, 1'b0, 1'b0);

        // Backpressure: one symbol held for five cycles with a byte waiting
        bp_bytes[0] = 8'h55; bp_bytes[1] = 8'h12; bp_bytes[2] = 8'h34;
        data_i = 8'h4A; data_k_i = 1'b0; data_valid_i = 1'b1; symbol_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_i = bp_bytes[0]; symbol_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_ready_low", 32'(encoder_ready_o), 32'(0));
            chk("bp_symbol_hold", 32'(symbol_o), 32'(m_sym));
            @(posedge clk_i); #1;
        end
        symbol_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = bp_bytes[i];
            @(negedge clk_i);
            chk("bp_thru_ready", 32'(encoder_ready_o), 32'(1));
            chk("bp_thru_valid", 32'(symbol_valid_o), 32'(1));
            @(posedge clk_i); #1;
        end
        data_valid_i = 1'b0;
        @(posedge clk_i); #1;

        // Random byte/K mix with random source and sink stalls
        n = 0; cyc = 0; did_rst = 1'b0;
        while (n < 10000 && cyc < 60000) begin
            @(negedge clk_i);
            acc = data_valid_i && encoder_ready_o && !rst_i;
            @(posedge clk_i); #1;
            cyc++;
            if (acc) n++;
            if (!data_valid_i || acc) begin
                data_valid_i = ($urandom_range(0, 9) < 8);
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    data_k_i = 1'b1; data_i = LEGAL_K[$urandom_range(0, 11)];
                end else if (r == 2) begin
                    data_k_i = 1'b1; data_i = 8'($urandom);
                end else begin
                    data_k_i = 1'b0; data_i = 8'($urandom);
                end
            end
            symbol_ready_i = ($urandom_range(0, 3) != 0);
            if (n >= 5000 && !did_rst) begin
                did_rst = 1'b1;
                #2 rst_i = 1'b1;
                #1;
                chk("async_rst_valid", 32'(symbol_valid_o), 32'(0));
                chk("async_rst_rd", 32'(rd_o), 32'(INIT_RD));
                @(posedge clk_i);
                #3 rst_i = 1'b0;
            end
        end
        chk("random_stream_done", 32'(n >= 10000), 32'(1));

        data_valid_i = 1'b0; symbol_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
